// File: rtl/rr_bus_mux.sv
// Parametrised N-to-1 bus multiplexer with a registered valid/ready output stage.
// Supports direct-select (legacy) and round-robin arbitration modes.
module rr_bus_mux #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_IN     = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mode,
  input  logic [SEL_WIDTH-1:0]         select,
  input  logic [NUM_IN-1:0]            in_valid,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in_data,
  output logic [NUM_IN-1:0]            in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [SEL_WIDTH-1:0]         out_chan
);

  logic [NUM_IN-1:0]     grant;
  logic [SEL_WIDTH-1:0]  grant_idx;
  logic [DATA_WIDTH-1:0] grant_data;
  logic [SEL_WIDTH-1:0]  rr_ptr;
  logic                  rr_found;
  int unsigned           rr_idx;
  logic                  load_en;
  logic                  xfer;

  always_comb begin
    grant    = '0;
    rr_found = 1'b0;
    rr_idx   = 0;
    if (!mode) begin
      // Out-of-range select simply matches no channel, so no grant is raised.
      for (int unsigned i = 0; i < NUM_IN; i++) begin
        if (32'(select) == i) grant[i] = in_valid[i];
      end
    end else begin
      for (int unsigned off = 0; off < NUM_IN; off++) begin
        rr_idx = 32'(rr_ptr) + off;
        if (rr_idx >= NUM_IN) rr_idx = rr_idx - NUM_IN;
        if (!rr_found && in_valid[rr_idx]) begin
          grant[rr_idx] = 1'b1;
          rr_found      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    grant_idx  = '0;
    grant_data = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (grant[i]) begin
        grant_idx  = SEL_WIDTH'(i);
        grant_data = in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // in_ready is held low while reset is asserted even though the output is empty.
  assign load_en  = !out_valid | out_ready;
  assign in_ready = rst_n ? (grant & {NUM_IN{load_en}}) : '0;
  assign xfer     = |in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      rr_ptr    <= '0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_chan  <= grant_idx;
        if (mode) begin
          if (grant_idx == SEL_WIDTH'(NUM_IN - 1)) rr_ptr <= '0;
          else                                     rr_ptr <= grant_idx + 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/rr_bus_mux.md
Name: rr_bus_mux

Overview:
- Parametrised successor to the fixed 16-bit 4-to-1 datapath mux.
- Selects one of NUM_IN data channels onto a single registered output, using a valid/ready handshake on each input and on the output.
- Two modes: direct select, which matches the legacy behaviour, and round-robin arbitration.
- Sits between multiple bus sources (register file ports, ALU, memory read, immediate) and the shared datapath bus of the simple computer.

Parameters:
- DATA_WIDTH, 16, width of every data channel and the output.
- NUM_IN, 4, number of input channels; legal range 2..16.
- SEL_WIDTH, 2, width of select and out_chan; must equal ceil(log2(NUM_IN)).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = direct select, 1 = round-robin.
- select  input  SEL_WIDTH  channel index used in mode 0; ignored in mode 1.
- in_valid  input  NUM_IN  bit i set: channel i presents data.
- in_data  input  NUM_IN*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- in_ready  output  NUM_IN  bit i set: channel i transfers this cycle.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the output word.
- out_data  output  DATA_WIDTH  registered selected word.
- out_chan  output  SEL_WIDTH  source channel index of out_data.

Behaviour:
- Reset: one clock, clk; rst_n is asynchronous and active-low. While rst_n = 0: out_valid = 0, out_data = 0, out_chan = 0, rr_ptr = 0, in_ready = 0. Reset mid-transfer discards the held word; no partial state survives.
- load_en = !out_valid | out_ready. The output stage accepts a new word only when it is empty or draining in the same cycle.
- grant is combinational, one-hot or zero. in_ready[i] = load_en & grant[i], so at most one bit of in_ready is set per cycle.
- Transfer on input i occurs when in_valid[i] & in_ready[i]. On that edge: out_data <= channel i data, out_chan <= i, out_valid <= 1.
- Latency: input transfer at edge N gives out_valid = 1 after edge N.
- Throughput: 1 word per cycle when out_ready is held high.
- Output hold: while out_valid & !out_ready, out_data and out_chan are stable and in_ready = 0.
- Drain with no new transfer (out_ready = 1, no grant): out_valid <= 0; out_data and out_chan keep their last values.
- Mode 0 (direct):
  - grant[select] = in_valid[select]; all other grant bits are 0.
  - select >= NUM_IN (non-power-of-two NUM_IN) gives no grant and no X propagation. This replaces the legacy X default.
  - rr_ptr is unchanged in mode 0.
- Mode 1 (round-robin):
  - Search starts at rr_ptr and proceeds upward with wrap: rr_ptr, rr_ptr+1, ..., NUM_IN-1, 0, ... The first channel with in_valid set wins.
  - After a transfer from channel k: rr_ptr <= k+1, wrapping NUM_IN-1 -> 0.
  - rr_ptr does not advance without a transfer, including when a grant is blocked by a full output.
- Mode changes take effect on the next grant evaluation. A word already held in the output is unaffected.
- An input that deasserts in_valid before its grant is simply skipped; no state is kept for it.
- Inputs are sampled only on transfer. in_data of non-granted channels is a don't-care.
- Registers: output data register, output valid flag, output channel register, and rr_ptr (SEL_WIDTH bits). No other storage.

Test Plan:
- Reset: assert rst_n = 0 mid-stream with out_valid = 1 -> out_valid, out_data and out_chan drop to 0 immediately, without waiting for a clock edge; after release the first round-robin grant goes to channel 0.
- Mode 0, legacy equivalence: NUM_IN = 4, all valid, in_data = {16'hDDDD, 16'hCCCC, 16'hBBBB, 16'hAAAA}, select = 2, out_ready = 1 -> in_ready = 4'b0100 and out_data = 16'hCCCC with out_chan = 2 one cycle later; repeat for selects 0, 1 and 3.
- Mode 1, fairness: all 4 channels continuously valid, out_ready = 1 -> out_chan sequence 0, 1, 2, 3, 0, 1 on consecutive cycles, with out_valid held high.
- Round-robin sparse and wrap: only channels 1 and 3 valid, rr_ptr = 2 -> grants alternate 3, 1, 3, 1; rr_ptr wraps 0 after each channel-3 grant.
- Backpressure: out_ready = 0 for 3 cycles with the output full -> out_data and out_chan stable, in_ready = 0, rr_ptr frozen; on out_ready = 1 a new word loads the same cycle and no data is lost or duplicated.
- Out-of-range select: NUM_IN = 3, SEL_WIDTH = 2, mode 0, select = 3, all valid -> in_ready = 0, out_valid stays 0, no X on any output.
